// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl
// Game-flow controller for an endless-runner ("dino") game.
//   IDLE -> RUN on a start-button rising edge. RUN -> HIT on collision.
//   HIT -> OVER after HIT_HOLD cycles. OVER -> RUN on the next start edge.
//   In RUN it generates the obstacle motion tick, advances the sprite
//   animation phase, counts passed obstacles into the score and raises the
//   obstacle speed every STEP_PASSES passes, up to MAX_SPEED.
//
// Optional feature macro: DINO_CTRL_HISCORE_EN
//   defined   -> hiscore keeps the best score, captured when a run ends
//   undefined -> hiscore is a constant 16'h0000 (no register or comparator)
//
// Ports
//   clk              system clock, rising edge
//   reset_n          asynchronous active-low reset
//   start_btn        start/replay button level (already synchronous)
//   collision        dino overlaps an obstacle this cycle
//   obstacle_passed  one-cycle pulse, an obstacle wrapped off-screen
//   motion_tick      one-cycle pulse, advance obstacles by speed
//   speed            obstacle step in pixels per tick
//   obstacles_reset  one-cycle pulse, reload obstacle start positions
//   anim_phase       sprite animation phase
//   state            IDLE=0, RUN=1, HIT=2, OVER=3
//   show_replay      high only in OVER
//   score            obstacles passed in the current run
//   hiscore          best score (see feature macro above)
module dino_game_ctrl #(
   parameter int TICK_DIV    = 2000000,
   parameter int STEP_PASSES = 12,
   parameter int MAX_SPEED   = 15,
   parameter int HIT_HOLD    = 25000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_btn,
   input  logic        collision,
   input  logic        obstacle_passed,
   output logic        motion_tick,
   output logic [3:0]  speed,
   output logic        obstacles_reset,
   output logic [1:0]  anim_phase,
   output logic [1:0]  state,
   output logic        show_replay,
   output logic [15:0] score,
   output logic [15:0] hiscore
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
   localparam int PASS_W = $clog2(STEP_PASSES + 1);

   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HIT_HOLD - 1);
   localparam logic [PASS_W-1:0] PASS_STEP  = PASS_W'(STEP_PASSES);
   localparam logic [3:0]        SPEED_CEIL = 4'(MAX_SPEED);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   state_t            state_r;
   logic              start_prev_r;
   logic [TICK_W-1:0] tick_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [PASS_W-1:0] pass_cnt_r;
   logic              motion_tick_r;
   logic              obstacles_reset_r;
   logic [3:0]        speed_r;
   logic [1:0]        anim_phase_r;
   logic              show_replay_r;
   logic [15:0]       score_r;

   logic              start_edge_s;
   logic [TICK_W-1:0] tick_nxt_s;
   logic [PASS_W-1:0] pass_nxt_s;
   logic [15:0]       score_nxt_s;
   logic [3:0]        speed_inc_s;

   // Next-value helpers: start edge, wrapping tick, saturating score/speed.
   always_comb begin
      start_edge_s = start_btn & ~start_prev_r;
      if (tick_cnt_r == TICK_LAST) begin
         tick_nxt_s = {TICK_W{1'b0}};
      end else begin
         tick_nxt_s = tick_cnt_r + TICK_W'(1);
      end
      pass_nxt_s = pass_cnt_r + PASS_W'(1);
      if (score_r == 16'hFFFF) begin
         score_nxt_s = score_r;
      end else begin
         score_nxt_s = score_r + 16'd1;
      end
      if (speed_r < SPEED_CEIL) begin
         speed_inc_s = speed_r + 4'd1;
      end else begin
         speed_inc_s = speed_r;
      end
   end

   // Game FSM with all of its registered outputs and internal counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r           <= ST_IDLE;
         start_prev_r      <= 1'b1;   // a button held through reset must not start
         tick_cnt_r        <= {TICK_W{1'b0}};
         hold_cnt_r        <= {HOLD_W{1'b0}};
         pass_cnt_r        <= {PASS_W{1'b0}};
         motion_tick_r     <= 1'b0;
         obstacles_reset_r <= 1'b0;
         speed_r           <= 4'd1;
         anim_phase_r      <= 2'd0;
         show_replay_r     <= 1'b0;
         score_r           <= 16'd0;
      end else begin
         start_prev_r      <= start_btn;
         motion_tick_r     <= 1'b0;
         obstacles_reset_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_OVER: begin
               if (start_edge_s) begin
                  state_r           <= ST_RUN;
                  obstacles_reset_r <= 1'b1;
                  speed_r           <= 4'd1;
                  score_r           <= 16'd0;
                  pass_cnt_r        <= {PASS_W{1'b0}};
                  tick_cnt_r        <= {TICK_W{1'b0}};
                  show_replay_r     <= 1'b0;
               end
            end
            ST_RUN: begin
               if (collision) begin
                  // Pass pulse and tick advance in the collision cycle are dropped.
                  state_r    <= ST_HIT;
                  hold_cnt_r <= {HOLD_W{1'b0}};
               end else begin
                  tick_cnt_r <= tick_nxt_s;
                  // Tick and phase step together, in the cycle the counter hits its last value.
                  if (tick_nxt_s == TICK_LAST) begin
                     motion_tick_r <= 1'b1;
                     anim_phase_r  <= anim_phase_r + 2'd1;
                  end
                  if (obstacle_passed) begin
                     score_r <= score_nxt_s;
                     if (pass_nxt_s == PASS_STEP) begin
                        pass_cnt_r <= {PASS_W{1'b0}};
                        speed_r    <= speed_inc_s;
                     end else begin
                        pass_cnt_r <= pass_nxt_s;
                     end
                  end
               end
            end
            ST_HIT: begin
               if (hold_cnt_r == HOLD_LAST) begin
                  state_r       <= ST_OVER;
                  hold_cnt_r    <= {HOLD_W{1'b0}};
                  show_replay_r <= 1'b1;
               end else begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign state           = state_r;
   assign motion_tick     = motion_tick_r;
   assign obstacles_reset = obstacles_reset_r;
   assign speed           = speed_r;
   assign anim_phase      = anim_phase_r;
   assign show_replay     = show_replay_r;
   assign score           = score_r;

`ifdef DINO_CTRL_HISCORE_EN
   logic [15:0] hiscore_r;

   // Capture the best score at the moment a run ends in a collision.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hiscore_r <= 16'h0000;
      end else if ((state_r == ST_RUN) && collision && (score_r > hiscore_r)) begin
         hiscore_r <= score_r;
      end
   end

   assign hiscore = hiscore_r;
`else
   assign hiscore = 16'h0000;
`endif

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed testbench for dino_game_ctrl with small parameters
// (TICK_DIV=4, STEP_PASSES=3, MAX_SPEED=3, HIT_HOLD=5).
module tb_dino_game_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start_btn;
   logic        collision;
   logic        obstacle_passed;
   logic        motion_tick;
   logic [3:0]  speed;
   logic        obstacles_reset;
   logic [1:0]  anim_phase;
   logic [1:0]  state;
   logic        show_replay;
   logic [15:0] score;
   logic [15:0] hiscore;

   int vec_cnt = 0;
   int err_cnt = 0;

`ifdef DINO_CTRL_HISCORE_EN
   localparam logic [15:0] HISCORE_AFTER_RUN = 16'd9;
`else
   localparam logic [15:0] HISCORE_AFTER_RUN = 16'd0;
`endif

   dino_game_ctrl #(
      .TICK_DIV   (4),
      .STEP_PASSES(3),
      .MAX_SPEED  (3),
      .HIT_HOLD   (5)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start_btn      (start_btn),
      .collision      (collision),
      .obstacle_passed(obstacle_passed),
      .motion_tick    (motion_tick),
      .speed          (speed),
      .obstacles_reset(obstacles_reset),
      .anim_phase     (anim_phase),
      .state          (state),
      .show_replay    (show_replay),
      .score          (score),
      .hiscore        (hiscore)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start_btn = 1'b1; collision = 1'b0; obstacle_passed = 1'b0;
      step(); step();
      vec_cnt++; if (state !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", state); end
      vec_cnt++; if (speed !== 4'd1) begin err_cnt++; $display("FAIL rst_speed: got %0d want 1", speed); end
      vec_cnt++; if ({motion_tick, obstacles_reset, show_replay} !== 3'b000) begin err_cnt++; $display("FAIL rst_pulses: got %b want 000", {motion_tick, obstacles_reset, show_replay}); end
      vec_cnt++; if (anim_phase !== 2'd0) begin err_cnt++; $display("FAIL rst_anim: got %0d want 0", anim_phase); end
      vec_cnt++; if (score !== 16'd0 || hiscore !== 16'd0) begin err_cnt++; $display("FAIL rst_scores: got %0d/%0d want 0/0", score, hiscore); end
      // Release reset with the button still held: it must not start.
      reset_n = 1'b1;
      step(); step(); step();
      vec_cnt++; if (state !== 2'd0) begin err_cnt++; $display("FAIL held_btn_no_start: got state %0d want 0", state); end
      start_btn = 1'b0;
      step();
      start_btn = 1'b1;
      step();   // RUN cycle 0
      vec_cnt++; if (state !== 2'd1) begin err_cnt++; $display("FAIL start_state: got %0d want 1", state); end
      vec_cnt++; if (obstacles_reset !== 1'b1) begin err_cnt++; $display("FAIL start_obs_reset: got %b want 1", obstacles_reset); end
      vec_cnt++; if (speed !== 4'd1) begin err_cnt++; $display("FAIL start_speed: got %0d want 1", speed); end
   endtask

   task automatic test_motion();
      int ticks;
      ticks = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 1) begin
            vec_cnt++; if (obstacles_reset !== 1'b0) begin err_cnt++; $display("FAIL obs_reset_single: got %b want 0", obstacles_reset); end
            start_btn = 1'b0;
         end
         vec_cnt++;
         if (motion_tick !== ((k % 4) == 3)) begin
            err_cnt++; $display("FAIL motion_tick_c%0d: got %b want %b", k, motion_tick, (k % 4) == 3);
         end
         if (motion_tick === 1'b1) ticks++;
      end
      vec_cnt++; if (ticks != 3) begin err_cnt++; $display("FAIL tick_count: got %0d want 3", ticks); end
      vec_cnt++; if (anim_phase !== 2'd3) begin err_cnt++; $display("FAIL anim_after_12: got %0d want 3", anim_phase); end
   endtask

   task automatic test_speed();
      logic [3:0] exp_speed;
      for (int i = 1; i <= 9; i++) begin
         obstacle_passed = 1'b1;
         step();
         obstacle_passed = 1'b0;
         step();
         exp_speed = (i >= 6) ? 4'd3 : ((i >= 3) ? 4'd2 : 4'd1);
         vec_cnt++; if (speed !== exp_speed) begin err_cnt++; $display("FAIL speed_pass%0d: got %0d want %0d", i, speed, exp_speed); end
         vec_cnt++; if (score !== 16'(i)) begin err_cnt++; $display("FAIL score_pass%0d: got %0d want %0d", i, score, i); end
      end
   endtask

   task automatic test_collision();
      // Tick counter is at 2 here, so a missed freeze would tick next cycle.
      collision = 1'b1; obstacle_passed = 1'b1;
      step();
      collision = 1'b0; obstacle_passed = 1'b0;
      vec_cnt++; if (state !== 2'd2) begin err_cnt++; $display("FAIL hit_state: got %0d want 2", state); end
      vec_cnt++; if (score !== 16'd9) begin err_cnt++; $display("FAIL hit_score: got %0d want 9", score); end
      vec_cnt++; if (motion_tick !== 1'b0) begin err_cnt++; $display("FAIL hit_tick: got %b want 0", motion_tick); end
      vec_cnt++; if (hiscore !== HISCORE_AFTER_RUN) begin err_cnt++; $display("FAIL hiscore_capture: got %0d want %0d", hiscore, HISCORE_AFTER_RUN); end
      for (int j = 1; j <= 5; j++) begin
         // A start edge and a pass pulse during HIT must both be ignored.
         start_btn       = (j == 1 || j == 2);
         obstacle_passed = (j == 2);
         step();
         vec_cnt++;
         if (state !== ((j == 5) ? 2'd3 : 2'd2)) begin
            err_cnt++; $display("FAIL hold_state_c%0d: got %0d want %0d", j, state, (j == 5) ? 3 : 2);
         end
         vec_cnt++;
         if (show_replay !== (j == 5)) begin
            err_cnt++; $display("FAIL show_replay_c%0d: got %b want %b", j, show_replay, j == 5);
         end
         vec_cnt++; if (motion_tick !== 1'b0) begin err_cnt++; $display("FAIL hit_no_tick_c%0d: got %b want 0", j, motion_tick); end
      end
      start_btn = 1'b0; obstacle_passed = 1'b0;
      for (int j = 0; j < 4; j++) begin
         obstacle_passed = (j == 1);
         step();
         vec_cnt++; if (motion_tick !== 1'b0) begin err_cnt++; $display("FAIL over_no_tick_c%0d: got %b want 0", j, motion_tick); end
      end
      obstacle_passed = 1'b0;
      vec_cnt++; if (state !== 2'd3) begin err_cnt++; $display("FAIL over_stays: got %0d want 3", state); end
      vec_cnt++; if (score !== 16'd9) begin err_cnt++; $display("FAIL over_score_hold: got %0d want 9", score); end
      vec_cnt++; if (speed !== 4'd3) begin err_cnt++; $display("FAIL over_speed_hold: got %0d want 3", speed); end
      vec_cnt++; if (anim_phase !== 2'd3) begin err_cnt++; $display("FAIL over_anim_hold: got %0d want 3", anim_phase); end
   endtask

   task automatic test_replay();
      start_btn = 1'b1;
      step();
      vec_cnt++; if (state !== 2'd1) begin err_cnt++; $display("FAIL replay_state: got %0d want 1", state); end
      vec_cnt++; if (obstacles_reset !== 1'b1) begin err_cnt++; $display("FAIL replay_obs_reset: got %b want 1", obstacles_reset); end
      vec_cnt++; if (score !== 16'd0) begin err_cnt++; $display("FAIL replay_score: got %0d want 0", score); end
      vec_cnt++; if (speed !== 4'd1) begin err_cnt++; $display("FAIL replay_speed: got %0d want 1", speed); end
      vec_cnt++; if (show_replay !== 1'b0) begin err_cnt++; $display("FAIL replay_show: got %b want 0", show_replay); end
      vec_cnt++; if (hiscore !== HISCORE_AFTER_RUN) begin err_cnt++; $display("FAIL replay_hiscore: got %0d want %0d", hiscore, HISCORE_AFTER_RUN); end
      start_btn = 1'b0;
   endtask

   task automatic test_async_reset();
      int ticks;
      ticks = 0;
      for (int k = 1; k <= 7; k++) begin
         obstacle_passed = (k == 1);
         step();
         if (motion_tick === 1'b1) ticks++;
      end
      obstacle_passed = 1'b0;
      vec_cnt++; if (ticks != 2 || motion_tick !== 1'b1) begin err_cnt++; $display("FAIL pre_reset_ticks: got %0d/%b want 2/1", ticks, motion_tick); end
      vec_cnt++; if (score !== 16'd1 || anim_phase !== 2'd1) begin err_cnt++; $display("FAIL pre_reset_run: got score %0d anim %0d want 1 1", score, anim_phase); end
      // Assert reset well away from any clock edge.
      #1 reset_n = 1'b0;
      #1;
      vec_cnt++; if (state !== 2'd0) begin err_cnt++; $display("FAIL async_state: got %0d want 0", state); end
      vec_cnt++; if (motion_tick !== 1'b0) begin err_cnt++; $display("FAIL async_tick: got %b want 0", motion_tick); end
      vec_cnt++; if (score !== 16'd0 || anim_phase !== 2'd0) begin err_cnt++; $display("FAIL async_score_anim: got %0d/%0d want 0/0", score, anim_phase); end
      vec_cnt++; if (speed !== 4'd1 || show_replay !== 1'b0 || obstacles_reset !== 1'b0) begin err_cnt++; $display("FAIL async_misc: got speed %0d replay %b obs %b want 1 0 0", speed, show_replay, obstacles_reset); end
      vec_cnt++; if (hiscore !== 16'd0) begin err_cnt++; $display("FAIL async_hiscore: got %0d want 0", hiscore); end
      step(); step();
      vec_cnt++; if (state !== 2'd0) begin err_cnt++; $display("FAIL reset_no_over: got %0d want 0", state); end
   endtask

   initial begin
      test_reset();
      test_motion();
      test_speed();
      test_collision();
      test_replay();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/dino_game_ctrl.md
DINO_GAME_CTRL -- requirements
Module: dino_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 2000000, clk cycles per motion tick (>=2).
REQ-002 SHALL have parameter STEP_PASSES, default 12, obstacle passes per speed increment (>=1).
REQ-003 SHALL have parameter MAX_SPEED, default 15, speed ceiling (1..15).
REQ-004 SHALL have parameter HIT_HOLD, default 25000000, clk cycles spent in HIT before OVER (>=1).
REQ-005 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start_btn  input  1  level from controller start/replay button, already synchronous to clk.
REQ-008 SHALL have port collision  input  1  level, dino overlaps an obstacle this cycle.
REQ-009 SHALL have port obstacle_passed  input  1  one-cycle pulse, an obstacle wrapped off-screen.
REQ-010 SHALL have port motion_tick  output  1  one-cycle pulse, advance obstacles by speed.
REQ-011 SHALL have port speed  output  4  current obstacle step in pixels per tick.
REQ-012 SHALL have port obstacles_reset  output  1  one-cycle pulse, reload obstacle start positions.
REQ-013 SHALL have port anim_phase  output  2  sprite animation phase.
REQ-014 SHALL have port state  output  2  IDLE=0, RUN=1, HIT=2, OVER=3.
REQ-015 SHALL have port show_replay  output  1  high only in OVER.
REQ-016 SHALL have port score  output  16  obstacles passed in the current run.
REQ-017 SHALL have port hiscore  output  16  best score (see Configuration).

Function
REQ-018 SHALL detect start as a registered rising edge of start_btn (high now, low previous cycle); a held level never re-triggers.
REQ-019 IDLE: start edge -> RUN; in the same cycle obstacles_reset=1, speed<=1, score<=0, pass count<=0, tick counter<=0.
REQ-020 RUN: the tick counter SHALL count 0..TICK_DIV-1 and wrap; motion_tick=1 exactly in the cycle the counter equals TICK_DIV-1.
REQ-021 anim_phase SHALL increment modulo 4 on every motion_tick and hold otherwise.
REQ-022 RUN: each obstacle_passed pulse SHALL increment score, saturating at 16'hFFFF.
REQ-023 RUN: the pass count SHALL increment per pulse; the pulse that brings it to STEP_PASSES clears it and sets speed<=min(speed+1, MAX_SPEED).
REQ-024 RUN: collision=1 -> HIT next cycle; obstacle_passed in the same cycle SHALL be ignored; motion_tick SHALL NOT assert in that cycle.
REQ-025 HIT: the tick counter freezes; the hold counter counts HIT_HOLD cycles and then transitions to OVER; start edges are ignored.
REQ-026 OVER: show_replay=1; the tick counter stays frozen; a start edge behaves exactly as REQ-019.
REQ-027 Outside RUN: motion_tick=0; obstacle_passed is ignored; speed, score and anim_phase hold.
REQ-028 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-029 reset_n low SHALL immediately force: state=IDLE, motion_tick=0, obstacles_reset=0, speed=1, anim_phase=0, score=0, show_replay=0, all internal counters=0, and the start-edge history register=1 (a button held through reset does not start).
REQ-030 reset_n SHALL clear hiscore to 0; reset asserted mid-run abandons the run with no OVER entry.

Configuration
REQ-031 With DINO_CTRL_HISCORE_EN defined: on the RUN->HIT transition, hiscore<=score if score>hiscore; otherwise it holds.
REQ-032 Without DINO_CTRL_HISCORE_EN: hiscore is tied to 16'h0000 and no comparator or register is built.

Verification (TICK_DIV=4, STEP_PASSES=3, MAX_SPEED=3, HIT_HOLD=5)
REQ-033 Reset with start_btn held high, then release and press -> one obstacles_reset pulse, state=1, speed=1.
REQ-034 Run 12 cycles -> motion_tick pulses at cycles 3, 7 and 11 after entering RUN; anim_phase=3.
REQ-035 Send 9 obstacle_passed pulses -> speed follows 2, 3, 3 (saturates); score=9.
REQ-036 Assert collision together with obstacle_passed -> score unchanged; state=2; state=3 five cycles later; show_replay=1; no motion_tick in HIT or OVER.
REQ-037 In OVER, give a start edge -> obstacles_reset pulse, state=1, score=0, speed=1; with DINO_CTRL_HISCORE_EN defined, hiscore=9.
REQ-038 Assert reset_n low in RUN after 2 ticks -> all outputs at reset values asynchronously, before the next clk edge.
